// File: rtl/alarm_controller.sv
// Night-time door alarm: arming delay, entry delay, timed siren and a
// saturating trigger counter, all sequenced by one down-counter.
module alarm_controller #(
    parameter int ARM_DELAY   = 8,
    parameter int ENTRY_DELAY = 4,
    parameter int SIREN_TIME  = 16
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       porta,
    input  logic       relogio,
    input  logic       interruptor,
    output logic       sirene,
    output logic       armado,
    output logic [2:0] estado,
    output logic [7:0] contagem,
    output logic [3:0] disparos
);

    typedef enum logic [2:0] {
        DESARMADO = 3'd0,
        ARMANDO   = 3'd1,
        ARMADO    = 3'd2,
        ENTRADA   = 3'd3,
        DISPARADO = 3'd4
    } state_t;

    localparam logic [7:0] ARM_LOAD   = 8'(ARM_DELAY - 1);
    localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DELAY - 1);
    localparam logic [7:0] SIREN_LOAD = 8'(SIREN_TIME - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] count_nxt;
    logic       trigger;
    logic       habilita;

    assign habilita = ~relogio & ~interruptor;
    assign estado   = state;

    // Losing the night/override enable drops straight back to disarmed from
    // any state, including the unused encodings.
    always_comb begin
        state_nxt = state;
        count_nxt = contagem;
        trigger   = 1'b0;
        if (!habilita) begin
            state_nxt = DESARMADO;
            count_nxt = 8'd0;
        end else begin
            case (state)
                DESARMADO: begin
                    state_nxt = ARMANDO;
                    count_nxt = ARM_LOAD;
                end
                ARMANDO: begin
                    if (contagem != 8'd0) begin
                        count_nxt = contagem - 8'd1;
                    end else if (porta) begin
                        count_nxt = ARM_LOAD;
                    end else begin
                        state_nxt = ARMADO;
                        count_nxt = 8'd0;
                    end
                end
                ARMADO: begin
                    if (porta) begin
                        state_nxt = ENTRADA;
                        count_nxt = ENTRY_LOAD;
                    end else begin
                        count_nxt = 8'd0;
                    end
                end
                ENTRADA: begin
                    if (contagem != 8'd0) begin
                        count_nxt = contagem - 8'd1;
                    end else begin
                        state_nxt = DISPARADO;
                        count_nxt = SIREN_LOAD;
                        trigger   = 1'b1;
                    end
                end
                DISPARADO: begin
                    if (contagem != 8'd0) begin
                        count_nxt = contagem - 8'd1;
                    end else begin
                        state_nxt = ARMADO;
                        count_nxt = 8'd0;
                    end
                end
                default: begin
                    state_nxt = DESARMADO;
                    count_nxt = 8'd0;
                end
            endcase
        end
    end

    // Siren and armed flags are registered from the next state so they
    // line up with estado on every edge.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state    <= DESARMADO;
            contagem <= 8'd0;
            disparos <= 4'd0;
            sirene   <= 1'b0;
            armado   <= 1'b0;
        end else begin
            state    <= state_nxt;
            contagem <= count_nxt;
            if (trigger && disparos != 4'd15) begin
                disparos <= disparos + 4'd1;
            end
            sirene <= (state_nxt == DISPARADO);
            armado <= (state_nxt == ARMADO) || (state_nxt == ENTRADA) ||
                      (state_nxt == DISPARADO);
        end
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter ARM_DELAY, default 8, cycles between arm request and armed; legal 1..255.
REQ-002 Parameter ENTRY_DELAY, default 4, cycles from door opening while armed to siren; legal 1..255.
REQ-003 Parameter SIREN_TIME, default 16, cycles the siren stays on per trigger; legal 1..255.
REQ-004 clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 porta  input  1  door sensor; 1 = open.
REQ-007 relogio  input  1  day/night clock; 0 = night (alarm period).
REQ-008 interruptor  input  1  manual override; 1 = alarm disabled.
REQ-009 sirene  output  1  siren drive; 1 = sounding.
REQ-010 armado  output  1  1 while in ARMADO, ENTRADA or DISPARADO.
REQ-011 estado  output  3  current state code: DESARMADO=0, ARMANDO=1, ARMADO=2, ENTRADA=3, DISPARADO=4.
REQ-012 contagem  output  8  current value of the delay down-counter.
REQ-013 disparos  output  4  number of siren triggers since reset, saturating.

Function
REQ-014 Internal signal habilita = ~relogio & ~interruptor, evaluated combinationally each cycle from the current inputs.
REQ-015 All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-016 habilita = 0 in any state other than DESARMADO -> next state DESARMADO, contagem -> 0; this rule has priority over every other transition.
REQ-017 DESARMADO: habilita = 1 -> ARMANDO, contagem loaded with ARM_DELAY-1; else stay, contagem held at 0.
REQ-018 ARMANDO: contagem > 0 -> decrement by 1 per cycle, stay.
REQ-019 ARMANDO, contagem = 0, porta = 0 -> ARMADO, contagem stays 0.
REQ-020 ARMANDO, contagem = 0, porta = 1 -> stay ARMANDO, contagem reloaded with ARM_DELAY-1 (door must be closed to finish arming).
REQ-021 ARMADO: porta = 1 -> ENTRADA, contagem loaded with ENTRY_DELAY-1; else stay, contagem 0.
REQ-022 ENTRADA: contagem > 0 -> decrement, stay; contagem = 0 -> DISPARADO, contagem loaded with SIREN_TIME-1, disparos incremented.
REQ-023 ENTRADA: door closing (porta returning to 0) does not cancel the entry delay; only habilita = 0 cancels.
REQ-024 DISPARADO: sirene = 1; contagem > 0 -> decrement, stay; contagem = 0 -> ARMADO (re-arm); if porta is still 1 the ARMADO rule then moves to ENTRADA on the following cycle.
REQ-025 sirene = 1 exactly in DISPARADO, i.e. SIREN_TIME consecutive cycles per uninterrupted trigger.
REQ-026 disparos saturates at 15; further triggers leave it at 15; it is cleared only by reset.
REQ-027 Total latency in ENTRADA: siren asserts ENTRY_DELAY cycles after the first cycle estado = 3.
REQ-028 Counter never underflows; decrement occurs only when contagem > 0.
REQ-029 Unused state encodings 5..7 -> DESARMADO on the next clock, contagem 0.

Reset
REQ-030 reset = 1 at a rising edge -> estado = DESARMADO, contagem = 0, disparos = 0, sirene = 0, armado = 0, regardless of state or inputs.
REQ-031 reset has priority over all other transitions, including mid-countdown and mid-siren; a siren is cut off on the same edge.
REQ-032 While reset is held, no state advances; the first transition is evaluated on the first edge with reset = 0.

Verification
REQ-033 Reset, relogio=0, interruptor=0, porta=0 -> ARMANDO with contagem=7 after 1 edge, ARMADO (armado=1) after 8 more edges.
REQ-034 Armed, porta pulsed 1 for one cycle -> ENTRADA with contagem 3, sirene=1 after 4 more edges, held 16 cycles, then ARMADO, disparos=1.
REQ-035 ARMANDO with porta=1 held -> contagem reloads to 7 each time it reaches 0, ARMADO never reached until porta=0.
REQ-036 DISPARADO with contagem=10, interruptor set to 1 -> DESARMADO, sirene=0, contagem=0 on the next edge; disparos unchanged.
REQ-037 Porta held 1 across 17 complete trigger cycles -> disparos stops at 15; sirene toggles with 1-cycle ARMADO gap plus 4-cycle ENTRADA gap between bursts.
REQ-038 reset asserted during ENTRADA with contagem=2 -> all outputs at reset values on that edge; no siren afterwards while reset held.
